// File: rtl/iris_feature_loader.sv
// iris_feature_loader: four-feature entry sequencer with settle-and-latch of classifier result; `IRIS_HIST_EN adds per-species result counters
module iris_feature_loader #(
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_next,
  input  logic        btn_clear,
  input  logic [3:0]  sw_val,
  output logic [3:0]  sl,
  output logic [3:0]  sw,
  output logic [3:0]  pl,
  output logic [3:0]  pw,
  output logic [1:0]  field_sel,
  output logic        loading,
  input  logic [3:0]  species_in,
  input  logic [31:0] final_in,
  output logic [3:0]  species_out,
  output logic [31:0] conf_out,
  output logic        result_valid
`ifdef IRIS_HIST_EN
  ,
  output logic [7:0]  cnt_setosa,
  output logic [7:0]  cnt_versicolor,
  output logic [7:0]  cnt_virginica
`endif
);
  typedef enum logic [2:0] {LOAD_SL, LOAD_SW, LOAD_PL, LOAD_PW, SETTLE, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);
  state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0] prev_q;
  logic done_hit;
  // field index and loading flag decoded from state; done_hit marks the edge that latches a result
  always_comb begin
    field_sel = (state_q == LOAD_SL) ? 2'd0 : (state_q == LOAD_SW) ? 2'd1 : (state_q == LOAD_PL) ? 2'd2 : 2'd3;
    loading = (state_q != SETTLE) && (state_q != DONE);
    done_hit = !btn_clear && (state_q == SETTLE) && (species_in == prev_q) && (cnt_q == LAST);
  end
  // entry sequencer, settle counter and result latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_SL;
      {sl, sw, pl, pw} <= '0;
      species_out <= '0;
      conf_out <= '0;
      result_valid <= 1'b0;
      cnt_q <= '0;
      prev_q <= '0;
    end else if (btn_clear) begin
      state_q <= LOAD_SL;
      {sl, sw, pl, pw} <= '0;
      species_out <= '0;
      conf_out <= '0;
      result_valid <= 1'b0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        LOAD_SL: if (btn_next) begin sl <= sw_val; state_q <= LOAD_SW; end
        LOAD_SW: if (btn_next) begin sw <= sw_val; state_q <= LOAD_PL; end
        LOAD_PL: if (btn_next) begin pl <= sw_val; state_q <= LOAD_PW; end
        LOAD_PW: if (btn_next) begin
          pw <= sw_val;
          cnt_q <= '0;
          prev_q <= species_in;
          state_q <= SETTLE;
        end
        SETTLE: begin
          prev_q <= species_in;
          if (species_in != prev_q) cnt_q <= '0;
          else if (cnt_q == LAST) begin
            species_out <= species_in;
            conf_out <= final_in;
            result_valid <= 1'b1;
            state_q <= DONE;
          end else cnt_q <= cnt_q + 1'b1;
        end
        DONE: if (btn_next) begin result_valid <= 1'b0; state_q <= LOAD_SL; end
        default: state_q <= LOAD_SL;
      endcase
    end
  end
`ifdef IRIS_HIST_EN
  // saturating per-species tallies of latched results, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_setosa <= '0;
      cnt_versicolor <= '0;
      cnt_virginica <= '0;
    end else if (done_hit) begin
      if (species_in == 4'd0 && cnt_setosa != 8'hff) cnt_setosa <= cnt_setosa + 8'd1;
      if (species_in == 4'd1 && cnt_versicolor != 8'hff) cnt_versicolor <= cnt_versicolor + 8'd1;
      if (species_in == 4'd2 && cnt_virginica != 8'hff) cnt_virginica <= cnt_virginica + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_iris_feature_loader.sv
// tb_iris_feature_loader: randomized bench for iris_feature_loader against a sample-window reference model
module tb_iris_feature_loader;
  localparam int SC = 4;
  logic clk = 0, rst = 0, btn_next = 0, btn_clear = 0;
  logic [3:0] sw_val = 0, species_in = 0;
  logic [31:0] final_in = 0;
  logic [3:0] sl, sw, pl, pw, species_out;
  logic [1:0] field_sel;
  logic loading, result_valid;
  logic [31:0] conf_out;
  int pass_cnt = 0, total = 0;
  int phase;
  logic [3:0] mf[4];
  logic [3:0] mspec;
  logic [31:0] mconf;
  logic mvalid;
  logic [3:0] hq[$];
  int mh[3];
`ifdef IRIS_HIST_EN
  logic [7:0] cnt_setosa, cnt_versicolor, cnt_virginica;
`endif

  iris_feature_loader #(.SETTLE_CYCLES(SC), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .btn_clear(btn_clear), .sw_val(sw_val),
    .sl(sl), .sw(sw), .pl(pl), .pw(pw), .field_sel(field_sel), .loading(loading),
    .species_in(species_in), .final_in(final_in), .species_out(species_out),
    .conf_out(conf_out), .result_valid(result_valid)
`ifdef IRIS_HIST_EN
    , .cnt_setosa(cnt_setosa), .cnt_versicolor(cnt_versicolor), .cnt_virginica(cnt_virginica)
`endif
  );

  always #5 clk = ~clk;

  wire [55:0] dut_vec = {sl, sw, pl, pw, field_sel, loading, species_out, conf_out, result_valid};

  function automatic logic [55:0] exp_vec();
    return {mf[0], mf[1], mf[2], mf[3], (phase < 4) ? 2'(phase) : 2'd3, phase < 4, mspec, mconf, mvalid};
  endfunction

  // reference: result accepted once the last SC+1 sampled species (from the pw capture on) are identical
  task automatic tick();
    bit same;
    if (rst) begin
      phase = 0; mf = '{default: 4'd0}; mspec = 0; mconf = 0; mvalid = 0; hq.delete(); mh = '{default: 0};
    end else if (btn_clear) begin
      phase = 0; mf = '{default: 4'd0}; mspec = 0; mconf = 0; mvalid = 0; hq.delete();
    end else if (phase < 3) begin
      if (btn_next) begin mf[phase] = sw_val; phase++; end
    end else if (phase == 3) begin
      if (btn_next) begin mf[3] = sw_val; phase = 4; hq.delete(); hq.push_back(species_in); end
    end else if (phase == 4) begin
      hq.push_back(species_in);
      if (hq.size() > SC + 1) void'(hq.pop_front());
      same = 1;
      foreach (hq[i]) if (hq[i] != hq[0]) same = 0;
      if (hq.size() == SC + 1 && same) begin
        mspec = species_in; mconf = final_in; mvalid = 1; phase = 5;
        if (species_in < 3 && mh[species_in] < 255) mh[species_in]++;
      end
    end else if (btn_next) begin
      mvalid = 0; phase = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic press(input logic [3:0] v);
    sw_val = v; btn_next = 1; tick(); btn_next = 0;
  endtask

  task automatic clear();
    btn_clear = 1; tick(); btn_clear = 0;
  endtask

  task automatic test_reset();
    rst = 1; btn_next = 1; sw_val = 4'hf; tick(); rst = 0; btn_next = 0;
    total++; if (dut_vec !== exp_vec()) $display("FAIL reset_vec got %h want %h", dut_vec, exp_vec()); else pass_cnt++;
    total++; if ({field_sel, loading, result_valid} !== 4'b0010) $display("FAIL reset_flags got %b want 0010", {field_sel, loading, result_valid}); else pass_cnt++;
  endtask

  task automatic test_entry();
    logic [3:0] v[4] = '{4'd5, 4'd3, 4'd1, 4'd0};
    int k;
    clear();
    species_in = 0; final_in = $urandom;
    for (int i = 0; i < 4; i++) begin
      total++; if (field_sel !== 2'(i)) $display("FAIL entry_field got %0d want %0d", field_sel, i); else pass_cnt++;
      press(v[i]);
      total++; if (dut_vec !== exp_vec()) $display("FAIL entry_vec got %h want %h", dut_vec, exp_vec()); else pass_cnt++;
    end
    k = 0;
    while (!result_valid && k < 20) begin
      tick(); k++;
      total++; if (dut_vec !== exp_vec()) $display("FAIL entry_settle got %h want %h", dut_vec, exp_vec()); else pass_cnt++;
    end
    total++; if (k !== SC) $display("FAIL entry_latency got %0d want %0d", k, SC); else pass_cnt++;
    total++; if ({sl, sw, pl, pw, species_out} !== 20'h53100) $display("FAIL entry_features got %h want 53100", {sl, sw, pl, pw, species_out}); else pass_cnt++;
    total++; if (conf_out !== final_in) $display("FAIL entry_conf got %h want %h", conf_out, final_in); else pass_cnt++;
    final_in = ~final_in; species_in = 4'd7; tick(); tick();
    total++; if (dut_vec !== exp_vec()) $display("FAIL done_hold got %h want %h", dut_vec, exp_vec()); else pass_cnt++;
    press(4'd9);
    total++; if ({result_valid, field_sel, loading} !== 4'b0001) $display("FAIL done_next got %b want 0001", {result_valid, field_sel, loading}); else pass_cnt++;
  endtask

  task automatic test_toggle();
    int k;
    clear();
    species_in = 1; final_in = $urandom;
    for (int i = 0; i < 4; i++) press(4'($urandom));
    tick(); tick();
    species_in = 2; tick();
    total++; if (result_valid !== 1'b0) $display("FAIL toggle_early got %b want 0", result_valid); else pass_cnt++;
    k = 0;
    while (!result_valid && k < 20) begin
      tick(); k++;
      total++; if (dut_vec !== exp_vec()) $display("FAIL toggle_vec got %h want %h", dut_vec, exp_vec()); else pass_cnt++;
    end
    total++; if (k !== SC) $display("FAIL toggle_latency got %0d want %0d", k, SC); else pass_cnt++;
    total++; if (species_out !== 4'd2) $display("FAIL toggle_species got %0d want 2", species_out); else pass_cnt++;
    press(0);
  endtask

  task automatic test_clear();
    clear();
    press(4'd6); press(4'd7);
    clear();
    total++; if (dut_vec !== exp_vec() || {sl, sw} !== 8'h00) $display("FAIL clear_load got %h want %h", dut_vec, exp_vec()); else pass_cnt++;
    species_in = 0;
    for (int i = 0; i < 4; i++) press(4'(i + 8));
    tick(); tick();
    clear();
    for (int i = 0; i < 8; i++) begin
      tick();
      total++; if (dut_vec !== exp_vec() || result_valid !== 1'b0) $display("FAIL clear_settle got %h want %h", dut_vec, exp_vec()); else pass_cnt++;
    end
  endtask

  task automatic test_simul();
    clear();
    press(4'd4);
    sw_val = 4'hc; btn_next = 1; btn_clear = 1; tick(); btn_next = 0; btn_clear = 0;
    total++; if ({field_sel, sw, sl} !== 10'h0) $display("FAIL simul got %h want 000", {field_sel, sw, sl}); else pass_cnt++;
  endtask

  task automatic test_random();
    int k;
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 3) == 0) clear();
      species_in = 4'($urandom); final_in = $urandom;
      for (int i = 0; i < 4; i++) press(4'($urandom));
      k = 0;
      while (!result_valid && k < 60) begin
        btn_next = (k < 20) && ($urandom_range(0, 3) == 0);
        sw_val = 4'($urandom); final_in = $urandom;
        if (k < 20 && $urandom_range(0, 3) == 0) species_in = 4'($urandom);
        tick(); k++; btn_next = 0;
        total++; if (dut_vec !== exp_vec()) $display("FAIL random_vec got %h want %h", dut_vec, exp_vec()); else pass_cnt++;
      end
      total++; if (!result_valid) $display("FAIL random_timeout got 0 want 1"); else pass_cnt++;
      press(0);
    end
  endtask

`ifdef IRIS_HIST_EN
  task automatic run_one(input logic [3:0] s);
    int k;
    species_in = s; final_in = $urandom;
    for (int i = 0; i < 4; i++) press(4'($urandom));
    k = 0;
    while (!result_valid && k < 10) begin tick(); k++; end
    press(0);
  endtask

  task automatic test_hist();
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 300; i++) run_one(4'd1);
    run_one(4'd3);
    total++; if ({cnt_setosa, cnt_versicolor, cnt_virginica} !== 24'h00ff00 || cnt_versicolor !== 8'(mh[1])) $display("FAIL hist_sat got %h want 00ff00", {cnt_setosa, cnt_versicolor, cnt_virginica}); else pass_cnt++;
    clear();
    total++; if (cnt_versicolor !== 8'hff) $display("FAIL hist_clear got %h want ff", cnt_versicolor); else pass_cnt++;
    rst = 1; tick(); rst = 0;
    total++; if ({cnt_setosa, cnt_versicolor, cnt_virginica} !== 24'h0) $display("FAIL hist_rst got %h want 000000", {cnt_setosa, cnt_versicolor, cnt_virginica}); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_entry();
    test_toggle();
    test_clear();
    test_simul();
    test_random();
`ifdef IRIS_HIST_EN
    test_hist();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
